// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the PLL reset/lock manager and the PLL plus the
// downstream reset distribution.
interface pll_reset_ctrl_if #(
  parameter int RETRY_LIMIT = 3
);
  localparam int RETRY_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

  logic               pll_locked;
  logic               soft_reset;
  logic               pll_rst;
  logic               pll_ready;
  logic               lock_lost;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    input  pll_locked,
    input  soft_reset,
    output pll_rst,
    output pll_ready,
    output lock_lost,
    output fail,
    output retry_cnt
  );

  modport slave (
    output pll_locked,
    output soft_reset,
    input  pll_rst,
    input  pll_ready,
    input  lock_lost,
    input  fail,
    input  retry_cnt
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable lock with
// timeout and bounded retries, and flags readiness, lock loss and failure.
module pll_reset_ctrl #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RETRY_LIMIT         = 3
) (
  input  logic           refclk,
  input  logic           rst_n,
  pll_reset_ctrl_if.master bus
);
  localparam int RETRY_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);
  localparam int MAX_A   = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES
                                                                  : LOCK_STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    READY,
    FAIL
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [RETRY_W-1:0] retry_reg;
  logic               pll_rst_reg;
  logic               pll_ready_reg;
  logic               lock_lost_reg;
  logic               fail_reg;
  logic [1:0]         sync_reg;
  logic               locked_s;

  // Two-stage synchroniser for the PLL lock flag, which is asynchronous to refclk.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge refclk) begin
        if (!rst_n) sync_reg[gi] <= 1'b0;
        else        sync_reg[gi] <= bus.pll_locked;
      end
    end else begin : g_next
      always_ff @(posedge refclk) begin
        if (!rst_n) sync_reg[gi] <= 1'b0;
        else        sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign locked_s = sync_reg[1];

  // Outputs are set alongside each state change so they align with the state.
  always_ff @(posedge refclk) begin
    if (!rst_n || bus.soft_reset) begin
      state_reg     <= RESET_PLL;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      pll_rst_reg   <= 1'b1;
      pll_ready_reg <= 1'b0;
      lock_lost_reg <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      lock_lost_reg <= 1'b0;
      cnt_reg       <= cnt_reg + CNT_W'(1);
      case (state_reg)
        RESET_PLL: begin
          if (cnt_reg == HOLD_LAST) begin
            state_reg   <= WAIT_LOCK;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            if (retry_reg == RETRY_MAX) begin
              state_reg <= FAIL;
              fail_reg  <= 1'b1;
            end else begin
              state_reg <= RESET_PLL;
              retry_reg <= retry_reg + RETRY_W'(1);
            end
          end
        end
        STABLE: begin
          if (!locked_s) begin
            // Lock dropped before qualifying: restart the timeout, keep the PLL running.
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg     <= READY;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            pll_ready_reg <= 1'b1;
          end
        end
        READY: begin
          cnt_reg <= '0;
          if (!locked_s) begin
            state_reg     <= RESET_PLL;
            pll_rst_reg   <= 1'b1;
            pll_ready_reg <= 1'b0;
            lock_lost_reg <= 1'b1;
          end
        end
        FAIL: begin
          cnt_reg <= '0;
        end
        default: begin
          state_reg     <= RESET_PLL;
          cnt_reg       <= '0;
          retry_reg     <= '0;
          pll_rst_reg   <= 1'b1;
          pll_ready_reg <= 1'b0;
          fail_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst   = pll_rst_reg;
  assign bus.pll_ready = pll_ready_reg;
  assign bus.lock_lost = lock_lost_reg;
  assign bus.fail      = fail_reg;
  assign bus.retry_cnt = retry_reg;

endmodule
